// File: rtl/sha256_arbiter_if.sv
// Requester and core-side signals of the two-requester sha256 arbiter.
// The arbiter uses the slave modport; the environment (requesters and core) uses master.
interface sha256_arbiter_if;
  logic         req0;
  logic         req1;
  logic [511:0] data0;
  logic [511:0] data1;
  logic         done0;
  logic         done1;
  logic         err0;
  logic         err1;
  logic [255:0] hash_out;
  logic         busy;
  logic [511:0] core_data;
  logic         core_reset;
  logic         core_ready;
  logic [255:0] core_hash;

  modport slave (
    input  req0, req1, data0, data1, core_ready, core_hash,
    output done0, done1, err0, err1, hash_out, busy, core_data, core_reset
  );

  modport master (
    output req0, req1, data0, data1, core_ready, core_hash,
    input  done0, done1, err0, err1, hash_out, busy, core_data, core_reset
  );
endinterface

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256 core between two requesters:
// latch the winner's block, hold the core in reset, run with a timeout, report done/err.
module sha256_arbiter #(
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             reset,
  sha256_arbiter_if.slave  bus
);

  localparam int unsigned CMAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;          // LOAD countdown, then RUN cycle count
  logic           grant, grant_d;      // requester owning the current run
  logic           last, last_d;        // requester granted most recently
  logic           pick;
  logic [511:0]   core_data_q, core_data_d;
  logic [255:0]   hash_q, hash_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= 1'b0;
      last        <= 1'b1;
      core_data_q <= '0;
      hash_q      <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      grant       <= grant_d;
      last        <= last_d;
      core_data_q <= core_data_d;
      hash_q      <= hash_d;
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    grant_d        = grant;
    last_d         = last;
    core_data_d    = core_data_q;
    hash_d         = hash_q;
    pick           = 1'b0;
    bus.done0      = 1'b0;
    bus.done1      = 1'b0;
    bus.err0       = 1'b0;
    bus.err1       = 1'b0;
    bus.core_reset = 1'b1;
    bus.busy       = 1'b1;

    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.req0 || bus.req1) begin
          // Contention goes to whoever was not served last; a lone request wins outright.
          pick        = (bus.req0 && bus.req1) ? ~last : bus.req1;
          grant_d     = pick;
          last_d      = pick;
          core_data_d = pick ? bus.data1 : bus.data0;
          cnt_d       = CW'(RST_CYCLES - 1);
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RUN: begin
        bus.core_reset = 1'b0;
        if (bus.core_ready) begin
          hash_d  = bus.core_hash;
          state_d = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          bus.err0 = ~grant;
          bus.err1 = grant;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        bus.core_reset = 1'b0;
        bus.done0      = ~grant;
        bus.done1      = grant;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_data = core_data_q;
  assign bus.hash_out  = hash_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Scoreboard bench for sha256_arbiter: a behavioural core model with data-dependent latency,
// a queue-based arbitration model feeding expected outcomes, and an independent monitor.
module tb_sha256_arbiter;
  localparam int unsigned RST = 3;
  localparam int unsigned TO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sha256_arbiter_if bus();

  sha256_arbiter #(.RST_CYCLES(RST), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         who;
    logic         is_err;
    logic [511:0] data;
    logic [255:0] hash;
    int unsigned  lat;
  } exp_t;

  exp_t         q[$];
  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic         ptr_last = 1'b1;

  function automatic logic [255:0] ref_hash(input logic [511:0] d);
    return d[511:256] ^ ~d[255:0] ^ 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  endfunction

  // Core latency in cycles after leaving reset, chosen by the block's low nibble.
  function automatic int unsigned lat_of(input logic [511:0] d);
    return {28'd0, d[3:0]} + 1;
  endfunction

  function automatic logic [511:0] make_data();
    logic [511:0] d;
    int unsigned  sel;
    for (int unsigned i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    sel = $urandom_range(0, 3);
    case (sel)
      0:       d[3:0] = 4'd0;
      1:       d[3:0] = 4'd14;
      2:       d[3:0] = 4'd15;
      default: d[3:0] = 4'($urandom_range(0, 15));
    endcase
    return d;
  endfunction

  task automatic chk_int(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Core model: ready rises lat_of(block) cycles after core_reset drops.
  int unsigned ccnt;
  always @(posedge clk) begin
    if (bus.core_reset !== 1'b0) begin
      ccnt           <= 0;
      bus.core_ready <= 1'b0;
    end else begin
      ccnt <= ccnt + 1;
      if (ccnt + 1 == lat_of(bus.core_data)) begin
        bus.core_ready <= 1'b1;
        bus.core_hash  <= ref_hash(bus.core_data);
      end
    end
  end

  // Monitor
  int unsigned  lcnt = 0;
  int unsigned  rcnt = 0;
  bit           expect_idle = 1'b0;
  logic [255:0] cur_hash = '0;
  logic [3:0]   pulses;
  exp_t         e;

  always @(negedge clk) begin
    if (reset) begin
      lcnt = 0; rcnt = 0; expect_idle = 1'b0; cur_hash = '0;
    end else begin
      if (expect_idle) begin
        chk_int("idle_gap", 32'(bus.busy), 0);
        expect_idle = 1'b0;
      end
      if (bus.busy && bus.core_reset) lcnt++;
      else if (bus.busy && !bus.done0 && !bus.done1) begin
        if (rcnt == 0) begin
          chk_int("load_len", lcnt, RST);
          if (q.size() > 0) chk_vec("run_data", bus.core_data, q[0].data);
          lcnt = 0;
        end
        rcnt++;
      end
    end
    pulses = {bus.done0, bus.done1, bus.err0, bus.err1};
    if (pulses != 4'b0000) begin
      chk_int("one_hot", $countones(pulses), 1);
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got %b expected none", pulses);
      end else begin
        e = q.pop_front();
        chk_int("who_kind", 32'(pulses),
                e.is_err ? (e.who ? 32'd1 : 32'd2) : (e.who ? 32'd4 : 32'd8));
        if (!e.is_err) cur_hash = e.hash;
        chk_vec("hash_out", 512'(bus.hash_out), 512'(cur_hash));
        chk_int("run_len", rcnt, e.is_err ? TO : e.lat + 1);
      end
      rcnt = 0;
      expect_idle = 1'b1;
    end
  end

  task automatic push_exp(input logic who, input logic [511:0] d);
    exp_t x;
    x.who    = who;
    x.data   = d;
    x.hash   = ref_hash(d);
    x.lat    = lat_of(d);
    x.is_err = (x.lat >= TO);
    q.push_back(x);
    ptr_last = who;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned c = 0;
    while (q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk_int("drain", q.size(), 0);
  endtask

  task automatic check_reset_state();
    chk_int("rst_busy", 32'(bus.busy), 0);
    chk_int("rst_core_reset", 32'(bus.core_reset), 1);
    chk_vec("rst_core_data", bus.core_data, '0);
    chk_vec("rst_hash_out", 512'(bus.hash_out), '0);
    chk_int("rst_pulses", 32'({bus.done0, bus.done1, bus.err0, bus.err1}), 0);
  endtask

  // Both requesters raise req together; each holds it for its number of runs.
  task automatic run_round(input int unsigned w0, input int unsigned w1);
    logic [511:0] b0[$];
    logic [511:0] b1[$];
    int unsigned  r0, r1, i0, i1, k0, k1, cyc;
    logic         pk;
    for (int unsigned i = 0; i < w0; i++) b0.push_back(make_data());
    for (int unsigned i = 0; i < w1; i++) b1.push_back(make_data());
    r0 = w0; r1 = w1; i0 = 0; i1 = 0;
    while (r0 != 0 || r1 != 0) begin
      pk = (r0 != 0 && r1 != 0) ? ~ptr_last : (r1 != 0);
      if (pk) begin push_exp(1'b1, b1[i1]); i1++; r1--; end
      else    begin push_exp(1'b0, b0[i0]); i0++; r0--; end
    end
    bus.data0 = (w0 != 0) ? b0[0] : make_data();
    bus.data1 = (w1 != 0) ? b1[0] : make_data();
    bus.req0  = (w0 != 0);
    bus.req1  = (w1 != 0);
    k0 = 0; k1 = 0; cyc = 0;
    while ((k0 < w0 || k1 < w1) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.done0 || bus.err0) begin
        k0++;
        if (k0 < w0) bus.data0 = b0[k0]; else bus.req0 = 1'b0;
      end
      if (bus.done1 || bus.err1) begin
        k1++;
        if (k1 < w1) bus.data1 = b1[k1]; else bus.req1 = 1'b0;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk_int("round_budget", 32'(cyc < 1000), 1);
    drain(50);
    @(negedge clk);
  endtask

  task automatic wait_run(output bit ok);
    int unsigned c = 0;
    ok = 1'b0;
    while (!ok && c < 50) begin
      @(negedge clk);
      c++;
      if (bus.busy && !bus.core_reset) ok = 1'b1;
    end
  endtask

  initial begin
    logic [511:0] d;
    bit           ok;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);

    run_round(1, 1);
    run_round(2, 2);

    // Requester drops req in LOAD and scrambles its block mid-run.
    d = make_data();
    d[3:0] = 4'd6;
    push_exp(1'b0, d);
    bus.data0 = d;
    bus.req0  = 1'b1;
    repeat (2) @(negedge clk);
    bus.req0 = 1'b0;
    wait_run(ok);
    chk_int("reach_run_a", 32'(ok), 1);
    bus.data0 = ~d;
    drain(50);
    @(negedge clk);

    // Reset two cycles into RUN aborts silently.
    d = make_data();
    d[3:0] = 4'd10;
    bus.data0 = d;
    bus.req0  = 1'b1;
    wait_run(ok);
    chk_int("reach_run_b", 32'(ok), 1);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset    = 1'b0;
    ptr_last = 1'b1;
    @(negedge clk);
    run_round(0, 1);

    for (int unsigned r = 0; r < 20; r++) begin
      int unsigned w0, w1;
      w0 = $urandom_range(0, 3);
      w1 = $urandom_range(0, 3);
      if (w0 == 0 && w1 == 0) w0 = 1;
      run_round(w0, w1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sha256_arbiter.md
SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 Parameter: RST_CYCLES, default 3, number of cycles core_reset is held high with new data applied before a hash run (min 1).
REQ-002 Parameter: TIMEOUT, default 1023, maximum cycles spent in RUN waiting for core_ready before abort (min 1).
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req0 / req1  input  1 each  requester N wants a hash; level, held until doneN or errN.
REQ-006 Port: data0 / data1  input  512 each  padded message block of requester N, bit 511 = first message bit.
REQ-007 Port: done0 / done1  output  1 each  one-cycle pulse: hash_out valid for requester N.
REQ-008 Port: err0 / err1  output  1 each  one-cycle pulse: requester N's run timed out.
REQ-009 Port: hash_out  output  256  result of the last completed run; held until the next completion.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: core_data  output  512  block to the shared sha256 core.
REQ-012 Port: core_reset  output  1  active-high reset/start to the core.
REQ-013 Port: core_ready  input  1  core completion flag; level, high until the next core_reset.
REQ-014 Port: core_hash  input  256  core digest; valid while core_ready is high.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE; one state per cycle in DONE.
REQ-016 IDLE: core_reset=1; if any req is high, grant one, latch its data into core_data, load the cycle counter with RST_CYCLES-1, go to LOAD.
REQ-017 Arbitration is round-robin: with both req high, grant the requester not served last; the pointer updates only on grant; after reset, requester 0 has priority.
REQ-018 With one req high, grant it regardless of the pointer.
REQ-019 LOAD: core_reset=1 and core_data stable; when the counter reaches 0, go to RUN; LOAD lasts exactly RST_CYCLES cycles.
REQ-020 RUN: core_reset=0; when core_ready=1, capture core_hash into hash_out and go to DONE.
REQ-021 RUN: if TIMEOUT cycles pass without core_ready, pulse err of the granted requester, leave hash_out unchanged, and go to IDLE.
REQ-022 DONE: pulse done of the granted requester for exactly one cycle, then go to IDLE; core_reset=1 again from IDLE.
REQ-023 core_ready is ignored outside RUN.
REQ-024 core_data changes only on a grant in IDLE; requester data changes after grant have no effect.
REQ-025 If the granted req drops mid-run, the run completes and the done/err pulse is still issued.
REQ-026 A requester holding req through its done is re-arbitrated in the next IDLE; it cannot win twice in a row while the other requester is requesting.
REQ-027 Minimum grant-to-done: RST_CYCLES + 1 (first RUN cycle) + core latency; IDLE costs one cycle between runs.
REQ-028 done0/done1/err0/err1 are mutually exclusive and never asserted in the same cycle.

Reset
REQ-029 A synchronous reset forces IDLE and clears these outputs: core_reset=1, core_data=0, hash_out=0, busy=0, all done/err pulses=0; the round-robin pointer is reset to favour requester 0.
REQ-030 A reset in any state, including mid-run, aborts the run without any done/err pulse; the requester re-requests.

Verification
REQ-031 req0=1, data0=512'h03633cbe…5280…0108 (vector A), team sha256 core attached -> core_reset high exactly 3 cycles after grant, done0 pulse, hash_out=256'h92d0bf55…689956b2.
REQ-032 req0 and req1 rise in the same cycle after reset; data1=vector A with byte 0x52→0x53 (vector B) -> requester 0 served first, then requester 1; hash_out=256'h03497feb…3df1a7a5 at done1.
REQ-033 req0 and req1 held high for 4 runs -> grants alternate 0,1,0,1; the done pulses are never adjacent without an IDLE cycle between them.
REQ-034 Core replaced by a model that never raises core_ready, TIMEOUT=16 -> err0 pulses 16 cycles after RUN entry; hash_out unchanged; busy falls the next cycle.
REQ-035 Reset asserted 2 cycles into RUN -> no done/err pulse; all outputs at reset values the cycle after; a fresh req1 is then served normally.
REQ-036 req0 dropped during LOAD, data0 changed during RUN -> done0 still pulses; hash_out equals the hash of the originally latched data.
